list_sum_ctrl: RTL

- Control FSM sitting directly upstream of the linked-list summation datapath (the sum/next-pointer datapath). It drives that datapath's five control strobes and consumes its `next_zero` status.
- It sequences one list walk per `start` request:
  - clears the sum and pointer registers;
  - alternates "add node value" and "follow next pointer" until a null pointer is read.
- It reports completion with `done`, counts visited nodes, and flags runaway or cyclic lists via a node-limit watchdog.

---
 rtl/list_sum_ctrl_pkg.sv | 32 +++
 rtl/list_sum_ctrl_if.sv | 30 +++
 rtl/list_sum_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/list_sum_ctrl_pkg.sv
// Shared definitions for the linked-list summation controller:
// state encodings, strobe-vector layout and the Moore strobe decode.
package list_sum_ctrl_pkg;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StInit = 3'd1;
   localparam logic [2:0] StAdd  = 3'd2;
   localparam logic [2:0] StNext = 3'd3;
   localparam logic [2:0] StDone = 3'd4;
   localparam logic [2:0] StErr  = 3'd5;

   // Strobe vector layout: [LOAD_SUM LOAD_NEXT SUM_SEL NEXT_SEL ADDR_SEL]
   localparam int unsigned StbLoadSum  = 4;
   localparam int unsigned StbLoadNext = 3;
   localparam int unsigned StbSumSel   = 2;
   localparam int unsigned StbNextSel  = 1;
   localparam int unsigned StbAddrSel  = 0;

   typedef logic [4:0] strobe_t;

   function automatic strobe_t strobes_for(input logic [2:0] state);
      strobe_t stb;
      case (state)
         StInit:  stb = 5'b11000;
         StAdd:   stb = 5'b10101;
         StNext:  stb = 5'b01010;
         default: stb = 5'b00000;
      endcase
      return stb;
   endfunction

endpackage

// File: rtl/list_sum_ctrl_if.sv
// Control/status bundle between the list-walk controller and the sum/pointer datapath.
interface list_sum_ctrl_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             next_zero;
   logic             LOAD_SUM;
   logic             LOAD_NEXT;
   logic             SUM_SEL;
   logic             NEXT_SEL;
   logic             ADDR_SEL;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] node_count;

   // Controller side
   modport master (
      input  start, next_zero,
      output LOAD_SUM, LOAD_NEXT, SUM_SEL, NEXT_SEL, ADDR_SEL,
      output busy, done, err, node_count
   );

   // Requester/datapath side
   modport slave (
      output start, next_zero,
      input  LOAD_SUM, LOAD_NEXT, SUM_SEL, NEXT_SEL, ADDR_SEL,
      input  busy, done, err, node_count
   );
endinterface

// File: rtl/list_sum_ctrl.sv
// List-walk controller: clears sum/pointer, then alternates add-value and follow-pointer
// until a null pointer, with a node-limit watchdog that aborts cyclic lists.
module list_sum_ctrl
   import list_sum_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned MAX_NODES = 255
) (
   input  logic            clk,
   input  logic            rst,
   list_sum_ctrl_if.master bus
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_NODES);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   strobe_t          stb;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StInit;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         StInit: state_d = StAdd;
         StAdd: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StNext;
         end
         StNext: begin
            if (bus.next_zero) begin
               state_d = StDone;
            end else if (cnt_q == MaxCnt) begin
               state_d = StErr;
            end else begin
               state_d = StAdd;
            end
         end
         StDone: state_d = StIdle;
         StErr: begin
            err_d   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Moore outputs decoded from the registered state only
   always_comb begin
      stb = strobes_for(state_q);
   end

   assign bus.LOAD_SUM   = stb[StbLoadSum];
   assign bus.LOAD_NEXT  = stb[StbLoadNext];
   assign bus.SUM_SEL    = stb[StbSumSel];
   assign bus.NEXT_SEL   = stb[StbNextSel];
   assign bus.ADDR_SEL   = stb[StbAddrSel];
   assign bus.busy       = (state_q == StInit) || (state_q == StAdd) || (state_q == StNext);
   assign bus.done       = (state_q == StDone);
   assign bus.err        = err_q;
   assign bus.node_count = cnt_q;

endmodule
